// File: rtl/sram_ctrl.sv
// MEM-stage data-memory responder: each 32-bit load/store is split into two
// 16-bit accesses on an external asynchronous SRAM while ready is held low.
module sram_ctrl #(
    parameter logic [31:0] ADDR_BASE   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WORD_W = 17;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_wr_q, is_wr_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [17:0]         sram_addr_q, sram_addr_d;
    logic                we_n_q, we_n_d;
    logic                oe_n_q, oe_n_d;
    logic                ce_n_q, ce_n_d;
    logic                dq_oe_q, dq_oe_d;
    logic [15:0]         dq_out_q, dq_out_d;

    logic [31:0]         offset_c;
    logic [WORD_W-1:0]   word_c;
    logic                last_c;
    logic                hi_d;

    // Byte address to SRAM word index; the index wraps modulo 2^17
    assign offset_c = address - ADDR_BASE;
    assign word_c   = WORD_W'(offset_c >> 2);
    assign last_c   = (cnt_q == CNT_LAST);

    // Transfer sequencing and read capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready = ~rd_en & ~wr_en;
                if (rd_en | wr_en) begin
                    is_wr_d = wr_en;
                    word_d  = word_c;
                    wdata_d = write_data;
                    cnt_d   = '0;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (last_c) begin
                    if (!is_wr_q) begin
                        rdata_d[15:0] = SRAM_DQ;
                    end
                    cnt_d   = '0;
                    state_d = ST_HI;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HI: begin
                if (last_c) begin
                    if (!is_wr_q) begin
                        rdata_d[31:16] = SRAM_DQ;
                    end
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                ready   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // SRAM pins are registered from the next state so they line up with state_q
    always_comb begin
        we_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        ce_n_d      = 1'b1;
        dq_oe_d     = 1'b0;
        dq_out_d    = '0;
        sram_addr_d = sram_addr_q;
        hi_d        = (state_d == ST_HI);

        if ((state_d == ST_LO) || (state_d == ST_HI)) begin
            ce_n_d      = 1'b0;
            sram_addr_d = {word_d, hi_d};
            we_n_d      = ~is_wr_d;
            oe_n_d      = is_wr_d;
            dq_oe_d     = is_wr_d;
            dq_out_d    = hi_d ? wdata_d[31:16] : wdata_d[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            is_wr_q     <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            ce_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_wr_q     <= is_wr_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            ce_n_q      <= ce_n_d;
            dq_oe_q     <= dq_oe_d;
            dq_out_q    <= dq_out_d;
        end
    end

    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'bz;
    assign read_data = rdata_q;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_UB_N = ce_n_q;
    assign SRAM_LB_N = ce_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: behavioural async SRAM plus a transaction-level
// reference model; directed scenarios followed by randomized traffic.
module tb_sram_ctrl;

    localparam int unsigned ADDR_BASE = 1024;
    localparam int unsigned WAIT      = 2;
    localparam int unsigned TXN_LEN   = 1 + 2 * WAIT;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;
    logic        SRAM_OE_N;
    logic        SRAM_CE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_mem [int unsigned];
    int unsigned wr_words [$];
    logic [31:0] exp_rd = 32'h0;

    sram_ctrl #(
        .ADDR_BASE   (32'd1024),
        .WAIT_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (SRAM_DQ),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_OE_N  (SRAM_OE_N),
        .SRAM_CE_N  (SRAM_CE_N),
        .SRAM_UB_N  (SRAM_UB_N),
        .SRAM_LB_N  (SRAM_LB_N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 256Kx16 SRAM: a write lands once WE_N has been held WAIT cycles on one address
    logic [15:0] mem [0:262143];
    logic        sram_drive;
    logic        hold_valid = 1'b0;
    logic [17:0] hold_addr  = 18'h0;
    int unsigned hold_cnt   = 0;

    assign sram_drive = !SRAM_OE_N && !SRAM_CE_N && SRAM_WE_N;
    assign SRAM_DQ    = sram_drive ? mem[SRAM_ADDR] : 16'bz;

    always @(posedge clk) begin
        if (!SRAM_WE_N && !SRAM_CE_N) begin
            if (hold_valid && (SRAM_ADDR == hold_addr)) begin
                hold_cnt <= hold_cnt + 1;
                if (hold_cnt + 1 == WAIT) mem[SRAM_ADDR] <= SRAM_DQ;
            end else begin
                hold_valid <= 1'b1;
                hold_addr  <= SRAM_ADDR;
                hold_cnt   <= 1;
                if (WAIT == 1) mem[SRAM_ADDR] <= SRAM_DQ;
            end
        end else begin
            hold_valid <= 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_cycles(input int n);
        @(posedge clk); #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("idle_ready", 32'(ready), 32'd1);
            check_eq("idle_ce_n", 32'(SRAM_CE_N), 32'd1);
        end
    endtask

    // One request presented in the cycle after the previous negedge; ends at the DONE negedge
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input bit drop);
        int unsigned word;
        int unsigned we_cnt;
        int unsigned ha;
        logic [15:0] half;
        word   = ((addr - ADDR_BASE) >> 2) % 32'h20000;
        we_cnt = 0;
        if (!wr) exp_rd = {exp_mem[2 * word + 1], exp_mem[2 * word]};
        @(posedge clk); #1;
        rd_en      = rd;
        wr_en      = wr;
        address    = addr;
        write_data = data;
        for (int k = 0; k <= int'(TXN_LEN); k++) begin
            @(negedge clk);
            check_eq("ready", 32'(ready), 32'(k == int'(TXN_LEN)));
            if (k >= 1 && k <= int'(2 * WAIT)) begin
                ha = 2 * word + ((k > int'(WAIT)) ? 1 : 0);
                check_eq("sram_addr", 32'(SRAM_ADDR), ha);
                check_eq("ce_n", 32'(SRAM_CE_N), 32'd0);
                check_eq("ub_lb_n", 32'({SRAM_UB_N, SRAM_LB_N}), 32'd0);
                check_eq("we_n", 32'(SRAM_WE_N), 32'(!wr));
                check_eq("oe_n", 32'(SRAM_OE_N), 32'(wr));
                if (wr) half = (k > int'(WAIT)) ? data[31:16] : data[15:0];
                else    half = exp_mem[ha];
                check_eq("dq", 32'(SRAM_DQ), 32'(half));
            end else begin
                check_eq("ce_n_off", 32'(SRAM_CE_N), 32'd1);
                check_eq("we_n_off", 32'(SRAM_WE_N), 32'd1);
                check_eq("oe_n_off", 32'(SRAM_OE_N), 32'd1);
            end
            if (!SRAM_WE_N) we_cnt++;
            if (k == int'(TXN_LEN)) check_eq("read_data", read_data, exp_rd);
            if (k == 0 && drop) begin
                @(posedge clk); #1;
                rd_en      = 1'b0;
                wr_en      = 1'b0;
                address    = $urandom;
                write_data = $urandom;
            end
        end
        check_eq("we_cycles", we_cnt, wr ? 2 * WAIT : 0);
        if (wr) begin
            exp_mem[2 * word]     = data[15:0];
            exp_mem[2 * word + 1] = data[31:16];
            wr_words.push_back(word);
            check_eq("mem_lo", 32'(mem[2 * word]), 32'(data[15:0]));
            check_eq("mem_hi", 32'(mem[2 * word + 1]), 32'(data[31:16]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned w;
        int unsigned r;
        logic [31:0] a;
        rst        = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = 32'h0;
        write_data = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_pins", 32'({SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}), 32'h1F);
        check_eq("rst_addr", 32'(SRAM_ADDR), 32'd0);
        check_eq("rst_rdata", read_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle_cycles(2);

        // Basic write, read-back, back-to-back, simultaneous request
        run_txn(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0);
        check_eq("mem4", 32'(mem[4]), 32'h0000BEEF);
        check_eq("mem5", 32'(mem[5]), 32'h0000DEAD);
        idle_cycles(1);
        run_txn(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
        check_eq("rd_deadbeef", read_data, 32'hDEADBEEF);
        idle_cycles(1);
        run_txn(1'b0, 1'b1, 32'd1028, 32'h12345678, 1'b0);
        run_txn(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
        check_eq("rd_b2b", read_data, 32'h12345678);
        idle_cycles(1);
        run_txn(1'b1, 1'b1, 32'd1024, 32'hA5A55A5A, 1'b0);
        check_eq("both_mem0", 32'(mem[0]), 32'h00005A5A);
        check_eq("both_mem1", 32'(mem[1]), 32'h0000A5A5);
        check_eq("both_rdata", read_data, 32'h12345678);
        idle_cycles(1);

        // Reset during the high half of a write
        run_txn(1'b0, 1'b1, 32'd1040, 32'h11112222, 1'b0);
        @(posedge clk); #1;
        wr_en      = 1'b1;
        address    = 32'd1040;
        write_data = 32'hCAFEF00D;
        for (int k = 0; k <= int'(WAIT) + 1; k++) @(negedge clk);
        check_eq("pre_rst_addr", 32'(SRAM_ADDR), 32'd9);
        check_eq("pre_rst_we_n", 32'(SRAM_WE_N), 32'd0);
        rst   = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_ready", 32'(ready), 32'd1);
        check_eq("mid_rst_pins", 32'({SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}), 32'h1F);
        check_eq("mid_rst_rdata", read_data, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_mem8", 32'(mem[8]), 32'h0000F00D);
        check_eq("mid_rst_mem9", 32'(mem[9]), 32'h00001111);
        exp_mem[8] = 16'hF00D;
        exp_rd     = 32'h0;
        idle_cycles(1);

        // Request dropped after acceptance, then wrap below the base address
        run_txn(1'b0, 1'b1, 32'd1036, 32'h0BADCAFE, 1'b1);
        run_txn(1'b1, 1'b0, 32'd1036, 32'h0, 1'b0);
        check_eq("drop_rd", read_data, 32'h0BADCAFE);
        run_txn(1'b0, 1'b1, 32'd1020, 32'h600DF00D, 1'b0);
        check_eq("wrap_lo", 32'(mem[18'h3FFFE]), 32'h0000F00D);
        check_eq("wrap_hi", 32'(mem[18'h3FFFF]), 32'h0000600D);
        idle_cycles(1);

        // Randomized traffic against the reference model
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (wr_words.size() == 0 || r < 5) begin
                w = ($urandom_range(0, 7) == 0) ? 32'h1FFFF : $urandom_range(0, 15);
                a = ADDR_BASE + 4 * w + $urandom_range(0, 3) + 32'h80000 * $urandom_range(0, 1);
                run_txn(1'($urandom_range(0, 1)), 1'b1, a, $urandom, $urandom_range(0, 3) == 0);
            end else begin
                w = wr_words[$urandom_range(0, wr_words.size() - 1)];
                a = ADDR_BASE + 4 * w + $urandom_range(0, 3) + 32'h80000 * $urandom_range(0, 1);
                run_txn(1'b1, 1'b0, a, $urandom, $urandom_range(0, 3) == 0);
            end
            r = $urandom_range(0, 2);
            if (r != 0) idle_cycles(int'(r));
        end
        idle_cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Responder side of the MEM-stage data-memory interface.
- Accepts 32-bit read/write requests (rd_en/wr_en, address, write_data) from the MEM stage and serves each as two 16-bit accesses on an external asynchronous SRAM.
- Holds `ready` low while busy. The top level drives the pipeline freeze (superStall) as ~ready, so all stage registers hold until the word transfer completes.

Parameters:
- ADDR_BASE, 1024: byte offset of data memory; subtracted from `address` before mapping.
- WAIT_CYCLES, 2: cycles each 16-bit half-access is held on the SRAM pins; legal range 1..15.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, synchronous, active-low (0 = reset)
- rd_en  input  1  read request from MEM stage
- wr_en  input  1  write request from MEM stage
- address  input  32  byte address from ALU result
- write_data  input  32  store data
- read_data  output  32  load data, valid from the ready-high cycle of a read
- ready  output  1  1 = no access in progress / access finishing this cycle
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_ADDR  output  18  SRAM halfword address
- SRAM_WE_N  output  1  write enable, active-low
- SRAM_OE_N  output  1  output enable, active-low
- SRAM_CE_N  output  1  chip enable, active-low
- SRAM_UB_N  output  1  upper byte enable, active-low
- SRAM_LB_N  output  1  lower byte enable, active-low

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, counter=0, read_data=0.
  - SRAM_WE_N=1, OE_N=1, CE_N=1, UB_N=1, LB_N=1, SRAM_ADDR=0, DQ released (high-Z).
  - Reset mid-transfer abandons it immediately; a partially written word is not rolled back.
- Address map:
  - word = (address - ADDR_BASE) >> 2, 32-bit subtraction.
  - SRAM_ADDR = {word[16:0], h}, where h=0 for the low half and h=1 for the high half.
  - Word index wraps modulo 2^17; address bits [1:0] are ignored.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE:
    - If wr_en|rd_en: latch op (write if wr_en, else read), address and write_data; counter=0; go LO.
    - Otherwise stay.
  - LO:
    - Drive halfword 0 for WAIT_CYCLES cycles.
    - On the last cycle (counter==WAIT_CYCLES-1): if read, capture SRAM_DQ into read_data[15:0]; go HI; counter=0.
  - HI:
    - Same timing for halfword 1; a read captures into read_data[31:16].
    - Then go DONE.
  - DONE: one cycle, then unconditionally IDLE.
- ready (combinational):
  - ready = (state==IDLE & ~rd_en & ~wr_en) | (state==DONE).
  - It falls in the same cycle a request appears, so the pipeline freezes that cycle.
  - Stays low for exactly 1+2*WAIT_CYCLES cycles; high in the DONE cycle, when the MEM stage advances.
- Pin drive in LO/HI:
  - CE_N=0, UB_N=0, LB_N=0.
  - Write: WE_N=0, OE_N=1, DQ driven with the latched halfword.
  - Read: WE_N=1, OE_N=0, DQ high-Z.
  - In IDLE/DONE: WE_N=1, OE_N=1, CE_N=1, DQ high-Z.
- read_data is only updated by reads and holds its value through writes and idle cycles.
- Simultaneous rd_en & wr_en: treated as a write; rd_en ignored.
- Request inputs changing after acceptance have no effect; the latched transaction completes.
- A new request present in the cycle after DONE is accepted normally. There is no idle gap required beyond the DONE→IDLE cycle.
- Counter width is 4 bits and must not overflow for WAIT_CYCLES ≤ 15.

Test Plan (bench includes a 256K×16 behavioural SRAM model, WAIT_CYCLES=2):
- Write addr=1024+8, data=0xDEADBEEF:
  - ready low 5 cycles, high 6th.
  - SRAM[4]=0xBEEF, SRAM[5]=0xDEAD.
  - WE_N low exactly 4 cycles.
- Read addr=1032 after previous write:
  - ready high in DONE with read_data=0xDEADBEEF.
  - DQ never driven by DUT during read (check high-Z in LO/HI).
- Back-to-back write 1028/0x12345678 then read 1028 on the cycle after DONE:
  - second transfer starts without extra stall.
  - read_data=0x12345678.
- rd_en and wr_en both high, addr=1024, data=0xA5A5_5A5A:
  - performs a write (SRAM[0]=0x5A5A, SRAM[1]=0xA5A5).
  - read_data unchanged.
- rst=0 during HI of a write to 1040:
  - next edge: IDLE, ready=1 with no request, all SRAM control pins high, DQ high-Z.
  - SRAM[8] written, SRAM[9] untouched.
- Drop wr_en one cycle after acceptance: write still completes both halves; ready timing identical to scenario 1.
